// File: rtl/seq_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: state codes,
// decoder field encodings and PC select values.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StError  = 3'd7
    } state_t;

    localparam logic [1:0] RwNone  = 2'b00;
    localparam logic [1:0] RwAlu   = 2'b10;
    localparam logic [1:0] RwLoad  = 2'b01;
    localparam logic [1:0] RwStore = 2'b11;

    localparam logic [1:0] DsReg    = 2'b11;
    localparam logic [1:0] DsImm    = 2'b10;
    localparam logic [1:0] DsBranch = 2'b01;
    localparam logic [1:0] DsNone   = 2'b00;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    localparam logic [4:0] HaltOpcode = 5'b11111;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction/data memory handshake bundle; the sequencer is the master,
// the memories are the slave.
interface instr_sequencer_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr_in;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, instr_in, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, instr_in, dmem_ready
    );
endinterface

// File: rtl/wait_timer.sv
// Handshake wait counter: saturates at WAIT_MAX and flags expiry; clear has
// priority over enable.
module wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_MAX);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign expired = (cnt_q == CntMax);
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory-handshake
// timeout. Optional stall port enabled by defining INSTR_SEQ_STALL_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef INSTR_SEQ_STALL_EN
    input  logic                 stall,
`endif
    instr_sequencer_if.master    mem,
    output logic [31:0]          ir,
    output logic [4:0]           opcode,
    input  logic [4:0]           dec_alu_op,
    input  logic [1:0]           dec_data_src,
    input  logic [1:0]           dec_reg_write,
    input  logic [4:0]           dec_branch_op,
    input  logic [4:0]           dec_jump_op,
    input  logic                 alu_zero,
    output logic                 alu_en,
    output logic [4:0]           alu_op,
    output logic                 rf_we,
    output logic                 rf_src,
    output logic                 pc_en,
    output logic [1:0]           pc_sel,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_W-1:0]     instr_count
);
    state_t           st_q;
    logic [1:0]       data_src_q, reg_write_q;
    logic [4:0]       branch_op_q, jump_op_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             stall_act, waiting, ready_now, expired, is_halt, retire;

`ifdef INSTR_SEQ_STALL_EN
    assign stall_act = stall && busy;
`else
    assign stall_act = 1'b0;
`endif

    assign busy      = (st_q != StIdle) && (st_q != StHalt) && (st_q != StError);
    assign waiting   = (st_q == StFetch) || (st_q == StMem);
    assign ready_now = !stall_act && (((st_q == StFetch) && mem.imem_ready) ||
                                      ((st_q == StMem) && mem.dmem_ready));
    assign opcode    = ir[31:27];
    assign is_halt   = (opcode == HaltOpcode);

    // Leaving FETCH/MEM always coincides with either ready or timeout.
    wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!waiting || ready_now),
        .enable  (waiting && !stall_act),
        .expired (expired)
    );

    always_comb begin
        mem.imem_req = (st_q == StFetch);
        mem.dmem_req = (st_q == StMem);
        mem.dmem_we  = (st_q == StMem) && (reg_write_q == RwStore);
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        rf_src       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = PcPlus4;
        case (st_q)
            StExec: begin
                alu_en = 1'b1;
                if (reg_write_q == RwNone) begin
                    pc_en = 1'b1;
                    if (data_src_q == DsBranch) begin
                        if ((branch_op_q != 5'd0) && alu_zero) pc_sel = PcBranch;
                    end else if (jump_op_q != 5'd0) begin
                        pc_sel = PcJump;
                    end
                end
            end
            StMem: pc_en = mem.dmem_ready && (reg_write_q == RwStore);
            StWb: begin
                rf_we  = 1'b1;
                rf_src = (reg_write_q == RwLoad);
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (stall_act) begin
            alu_en = 1'b0;
            rf_we  = 1'b0;
            pc_en  = 1'b0;
        end
    end

    assign retire = pc_en || ((st_q == StDecode) && is_halt && !stall_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            ir          <= '0;
            alu_op      <= '0;
            data_src_q  <= '0;
            reg_write_q <= '0;
            branch_op_q <= '0;
            jump_op_q   <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (retire) count_q <= count_q + CNT_W'(1);
            if (!stall_act) begin
                case (st_q)
                    StIdle: if (start) st_q <= StFetch;
                    StFetch: begin
                        if (mem.imem_ready) begin
                            ir   <= mem.instr_in;
                            st_q <= StDecode;
                        end else if (expired) begin
                            st_q  <= StError;
                            err_q <= 1'b1;
                        end
                    end
                    StDecode: begin
                        alu_op      <= dec_alu_op;
                        data_src_q  <= dec_data_src;
                        reg_write_q <= dec_reg_write;
                        branch_op_q <= dec_branch_op;
                        jump_op_q   <= dec_jump_op;
                        st_q        <= is_halt ? StHalt : StExec;
                    end
                    StExec: begin
                        case (reg_write_q)
                            RwLoad, RwStore: st_q <= StMem;
                            RwAlu:           st_q <= StWb;
                            default:         st_q <= StFetch;
                        endcase
                    end
                    StMem: begin
                        if (mem.dmem_ready) begin
                            st_q <= (reg_write_q == RwStore) ? StFetch : StWb;
                        end else if (expired) begin
                            st_q  <= StError;
                            err_q <= 1'b1;
                        end
                    end
                    StWb:    st_q <= StFetch;
                    default: st_q <= st_q;
                endcase
            end
        end
    end

    assign state       = st_q;
    assign err         = err_q;
    assign instr_count = count_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed and randomized instructions
// checked cycle by cycle against a phase-level model of the control sequence.
module tb_instr_sequencer;
    localparam int unsigned WaitMax = 15;
    localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3;
    localparam logic [2:0] SMem = 3'd4, SWb = 3'd5, SHalt = 3'd6, SError = 3'd7;

    logic        clk = 1'b0;
    logic        rst, start, alu_zero;
    logic [4:0]  dec_alu_op, dec_branch_op, dec_jump_op;
    logic [1:0]  dec_data_src, dec_reg_write;
    logic [31:0] ir;
    logic [4:0]  opcode, alu_op;
    logic        alu_en, rf_we, rf_src, pc_en, busy, err;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
    logic [15:0] instr_count;
    logic [15:0] exp_count;
    int          passed = 0, total = 0, fails = 0;

    instr_sequencer_if mem ();

    always #5 clk = ~clk;

    instr_sequencer #(
        .WAIT_MAX (WaitMax),
        .CNT_W    (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
`ifdef INSTR_SEQ_STALL_EN
        .stall         (1'b0),
`endif
        .mem           (mem),
        .ir            (ir),
        .opcode        (opcode),
        .dec_alu_op    (dec_alu_op),
        .dec_data_src  (dec_data_src),
        .dec_reg_write (dec_reg_write),
        .dec_branch_op (dec_branch_op),
        .dec_jump_op   (dec_jump_op),
        .alu_zero      (alu_zero),
        .alu_en        (alu_en),
        .alu_op        (alu_op),
        .rf_we         (rf_we),
        .rf_src        (rf_src),
        .pc_en         (pc_en),
        .pc_sel        (pc_sel),
        .state         (state),
        .busy          (busy),
        .err           (err),
        .instr_count   (instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {imem_req, dmem_req, dmem_we, alu_en, rf_we, rf_src, pc_en, pc_sel, busy, err}
    function automatic logic [10:0] stb(input logic ireq, dreq, dwe, aen, rwe, rsrc, pen,
                                         input logic [1:0] psel, input logic bsy, er);
        return {ireq, dreq, dwe, aen, rwe, rsrc, pen, psel, bsy, er};
    endfunction

    task automatic expect_cycle(input string tag, input logic [2:0] st, input logic [10:0] s);
        #1;
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " strobes"}, 32'({mem.imem_req, mem.dmem_req, mem.dmem_we, alu_en, rf_we,
                                    rf_src, pc_en, pc_sel, busy, err}), 32'(s));
        chk({tag, " count"}, 32'(instr_count), 32'(exp_count));
    endtask

    task automatic scramble_dec();
        dec_alu_op    = 5'($urandom);
        dec_data_src  = 2'($urandom);
        dec_reg_write = 2'($urandom);
        dec_branch_op = 5'($urandom);
        dec_jump_op   = 5'($urandom);
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves it in FETCH, HALT or IDLE.
    task automatic run_instr(input string tag, input logic [31:0] instr, input logic [1:0] rw,
                             input logic [1:0] ds, input logic [4:0] bop, input logic [4:0] jop,
                             input logic zero, input int idly, input int ddly,
                             input bit rst_in_mem);
        logic [4:0] aop;
        logic [1:0] psel;
        logic       pen;
        aop = 5'($urandom);
        for (int i = 0; i <= idly; i++) begin
            mem.imem_ready = (i == idly);
            mem.instr_in   = (i == idly) ? instr : $urandom;
            scramble_dec();
            expect_cycle({tag, " fetch"}, SFetch, stb(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
            @(negedge clk);
        end
        mem.imem_ready = 1'($urandom);
        mem.instr_in   = $urandom;
        dec_alu_op = aop; dec_data_src = ds; dec_reg_write = rw;
        dec_branch_op = bop; dec_jump_op = jop;
        expect_cycle({tag, " decode"}, SDecode, stb(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        chk({tag, " ir"}, ir, instr);
        chk({tag, " opcode"}, 32'(opcode), 32'(instr[31:27]));
        @(negedge clk);
        scramble_dec();
        if (instr[31:27] == 5'b11111) begin
            exp_count++;
            expect_cycle({tag, " halt"}, SHalt, stb(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
            return;
        end
        alu_zero = zero;
        pen  = (rw == 2'b00);
        psel = 2'b00;
        if (pen && ds == 2'b01) psel = (bop != 0 && zero) ? 2'b01 : 2'b00;
        else if (pen && jop != 0) psel = 2'b10;
        expect_cycle({tag, " exec"}, SExec, stb(0, 0, 0, 1, 0, 0, pen, psel, 1, 0));
        chk({tag, " alu_op"}, 32'(alu_op), 32'(aop));
        @(negedge clk);
        alu_zero = 1'($urandom);
        if (pen) begin
            exp_count++;
            return;
        end
        if (rw != 2'b10) begin
            for (int i = 0; i <= ddly; i++) begin
                mem.dmem_ready = (i == ddly) && !rst_in_mem;
                if (rst_in_mem) rst = 1'b1;
                expect_cycle({tag, " mem"}, SMem,
                             stb(0, 1, rw == 2'b11, 0, 0, 0, mem.dmem_ready && rw == 2'b11,
                                 2'b00, 1, 0));
                @(negedge clk);
                if (rst_in_mem) begin
                    rst = 1'b0;
                    exp_count = '0;
                    expect_cycle({tag, " rst mid-mem"}, SIdle, stb(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
                    chk({tag, " rst ir"}, ir, 32'd0);
                    return;
                end
            end
            mem.dmem_ready = 1'($urandom);
            if (rw == 2'b11) begin
                exp_count++;
                return;
            end
        end
        expect_cycle({tag, " wb"}, SWb, stb(0, 0, 0, 0, 1, rw == 2'b01, 1, 2'b00, 1, 0));
        @(negedge clk);
        exp_count++;
    endtask

    initial begin
        logic [1:0] rw, ds;
        logic [4:0] bop, jop;
        int         idly, ddly;
        rst = 1'b1; start = 1'b0; alu_zero = 1'b0; exp_count = '0;
        mem.imem_ready = 1'b0; mem.dmem_ready = 1'b0; mem.instr_in = '0;
        scramble_dec();
        @(negedge clk); @(negedge clk);
        expect_cycle("reset", SIdle, 11'd0);
        chk("reset ir", ir, 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        expect_cycle("idle", SIdle, 11'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        run_instr("rtype", {5'b00011, 27'($urandom)}, 2'b10, 2'b11, 5'd0, 5'd0, 1'b0, 2, 0, 0);
        run_instr("br taken", {5'b01000, 27'($urandom)}, 2'b00, 2'b01, 5'd1, 5'd0, 1'b1, 0, 0, 0);
        run_instr("br not", {5'b01000, 27'($urandom)}, 2'b00, 2'b01, 5'd1, 5'd0, 1'b0, 1, 0, 0);
        run_instr("jump", {5'b01100, 27'($urandom)}, 2'b00, 2'b00, 5'd0, 5'd3, 1'b0, 0, 0, 0);
        run_instr("nop", {5'b00000, 27'($urandom)}, 2'b00, 2'b10, 5'd0, 5'd0, 1'b1, 0, 0, 0);
        run_instr("load", {5'b10000, 27'($urandom)}, 2'b01, 2'b10, 5'd0, 5'd0, 1'b0, 0, 3, 0);
        run_instr("store", {5'b10001, 27'($urandom)}, 2'b11, 2'b10, 5'd0, 5'd0, 1'b0, 1, 2, 0);
        run_instr("fetch edge", {5'b00001, 27'($urandom)}, 2'b10, 2'b11, 5'd0, 5'd0, 1'b0,
                  WaitMax, 0, 0);
        run_instr("mem edge", {5'b10000, 27'($urandom)}, 2'b01, 2'b10, 5'd0, 5'd0, 1'b0,
                  0, WaitMax, 0);

        for (int n = 0; n < 24; n++) begin
            rw   = 2'($urandom);
            ds   = 2'($urandom);
            bop  = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            jop  = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            idly = ($urandom_range(0, 5) == 0) ? WaitMax : $urandom_range(0, 3);
            ddly = ($urandom_range(0, 5) == 0) ? WaitMax : $urandom_range(0, 4);
            run_instr("rand", {5'($urandom_range(0, 30)), 27'($urandom)}, rw, ds, bop, jop,
                      1'($urandom), idly, ddly, 0);
        end

        run_instr("halt", {5'b11111, 27'($urandom)}, 2'b10, 2'b11, 5'd0, 5'd0, 1'b0, 1, 0, 0);
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expect_cycle("halt hold", SHalt, 11'd0);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        expect_cycle("halt reset", SIdle, 11'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_instr("ok before rst", {5'b00010, 27'($urandom)}, 2'b10, 2'b11, 5'd0, 5'd0, 1'b0,
                  0, 0, 0);
        run_instr("rst", {5'b10000, 27'($urandom)}, 2'b01, 2'b10, 5'd0, 5'd0, 1'b0, 0, 3, 1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mem.imem_ready = 1'b0;
        for (int i = 0; i <= int'(WaitMax); i++) begin
            expect_cycle("timeout fetch", SFetch, stb(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
            @(negedge clk);
        end
        expect_cycle("timeout", SError, stb(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            expect_cycle("error hold", SError, stb(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = '0;
        expect_cycle("error cleared", SIdle, 11'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
